// File: rtl/hamming_decoder.sv
// Two-stage Hamming(9,5) single-error-correcting decoder with valid/ready flow
// control and saturating statistics for delivered, corrected and bad words.
module hamming_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:8]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:4]       out_data,
  output logic [3:0]       out_syn,
  output logic             out_corr,
  output logic             out_bad,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_bad
);

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_out_hs;
  logic [0:8]       w_fixed;
  logic [0:4]       w_data;
  logic             w_corr;
  logic             w_bad;

  logic             r_vld_p1;
  logic [0:8]       r_code_p1;
  logic [3:0]       r_syn_p1;

  logic             r_vld_p2;
  logic [0:4]       r_data_p2;
  logic [3:0]       r_syn_p2;
  logic             r_corr_p2;
  logic             r_bad_p2;

  logic [CNT_W-1:0] r_cnt_words;
  logic [CNT_W-1:0] r_cnt_corr;
  logic [CNT_W-1:0] r_cnt_bad;

  function automatic logic [3:0] calc_syndrome(input logic [0:8] cw);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 9; i++) begin
      if (cw[i]) s = s ^ 4'(i + 1);
    end
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  assign w_s2_adv = !r_vld_p2 || out_ready;
  assign w_s1_adv = !r_vld_p1 || w_s2_adv;
  assign w_out_hs = r_vld_p2 && out_ready;
  assign in_ready = w_s1_adv;

  // Stage 1: capture the accepted codeword and its syndrome
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_adv) begin
      r_vld_p1 <= in_valid;
    end
    if (in_valid && w_s1_adv) begin
      r_code_p1 <= in_data;
      r_syn_p1  <= calc_syndrome(in_data);
    end
  end

  // Syndromes 10..15 point outside the 9-bit word, so nothing is flipped
  always_comb begin
    w_fixed = r_code_p1;
    for (int i = 0; i < 9; i++) begin
      if (r_syn_p1 == 4'(i + 1)) w_fixed[i] = ~r_code_p1[i];
    end
    w_data = {w_fixed[2], w_fixed[4], w_fixed[5], w_fixed[6], w_fixed[8]};
    w_corr = (r_syn_p1 != 4'd0) && (r_syn_p1 <= 4'd9);
    w_bad  = (r_syn_p1 >= 4'd10);
  end

  // Stage 2: corrected data and status presented downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_syn_p2  <= '0;
      r_corr_p2 <= 1'b0;
      r_bad_p2  <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_data_p2 <= w_data;
        r_syn_p2  <= r_syn_p1;
        r_corr_p2 <= w_corr;
        r_bad_p2  <= w_bad;
      end
    end
  end

  // Statistics: clear wins over a same-cycle handshake
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt_words <= '0;
      r_cnt_corr  <= '0;
      r_cnt_bad   <= '0;
    end else begin
      r_cnt_words <= sat_inc(r_cnt_words, w_out_hs);
      r_cnt_corr  <= sat_inc(r_cnt_corr, w_out_hs && r_corr_p2);
      r_cnt_bad   <= sat_inc(r_cnt_bad, w_out_hs && r_bad_p2);
    end
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;
  assign out_syn   = r_syn_p2;
  assign out_corr  = r_corr_p2;
  assign out_bad   = r_bad_p2;
  assign cnt_words = r_cnt_words;
  assign cnt_corr  = r_cnt_corr;
  assign cnt_bad   = r_cnt_bad;

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: directed vectors, exhaustive single-bit
// channel errors, backpressure, counter clear/saturation, reset and random traffic.
module tb_hamming_decoder;

  typedef struct packed {
    logic [0:4] data;
    logic [3:0] syn;
    logic       corr;
    logic       bad;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [0:8]  in_data = '0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;

  logic        in_ready, out_valid, out_corr, out_bad;
  logic [0:4]  out_data;
  logic [3:0]  out_syn;
  logic [15:0] cnt_words, cnt_corr, cnt_bad;

  logic        d2_in_ready, d2_out_valid, d2_out_corr, d2_out_bad;
  logic [0:4]  d2_out_data;
  logic [3:0]  d2_out_syn;
  logic [1:0]  d2_cnt_words, d2_cnt_corr, d2_cnt_bad;

  int n_pass = 0;
  int n_total = 0;

  exp_t sb[$];
  exp_t exp_cur;
  exp_t mon_e;

  int m_words = 0, m_corr = 0, m_bad = 0;
  int s_words = 0, s_corr = 0, s_bad = 0;
  bit         prev_stall = 0;
  logic [10:0] prev_fields = '0;

  always #5 clk = ~clk;

  hamming_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_syn(out_syn),
    .out_corr(out_corr), .out_bad(out_bad), .cnt_clr(cnt_clr),
    .cnt_words(cnt_words), .cnt_corr(cnt_corr), .cnt_bad(cnt_bad)
  );

  hamming_decoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data), .out_syn(d2_out_syn),
    .out_corr(d2_out_corr), .out_bad(d2_out_bad), .cnt_clr(cnt_clr),
    .cnt_words(d2_cnt_words), .cnt_corr(d2_cnt_corr), .cnt_bad(d2_cnt_bad)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Build a codeword whose syndrome is zero: data at positions 3,5,6,7,9,
  // parity bits at 1,2,4,8 chosen to cancel the XOR of the data positions.
  function automatic logic [0:8] encode(input logic [0:4] d);
    int pos[5] = '{3, 5, 6, 7, 9};
    logic [0:8] cw;
    int s;
    cw = '0;
    s = 0;
    for (int k = 0; k < 5; k++) begin
      if (d[k]) begin
        cw[pos[k] - 1] = 1'b1;
        s = s ^ pos[k];
      end
    end
    cw[0] = s[0];
    cw[1] = s[1];
    cw[3] = s[2];
    cw[7] = s[3];
    return cw;
  endfunction

  function automatic exp_t model_decode(input logic [0:8] cw);
    int s;
    logic [0:8] f;
    exp_t e;
    s = 0;
    for (int i = 0; i < 9; i++) if (cw[i]) s = s ^ (i + 1);
    f = cw;
    if (s >= 1 && s <= 9) f[s - 1] = ~f[s - 1];
    e.data = {f[2], f[4], f[5], f[6], f[8]};
    e.syn  = 4'(s);
    e.corr = (s >= 1 && s <= 9);
    e.bad  = (s >= 10);
    return e;
  endfunction

  function automatic exp_t mk(input logic [0:4] d, input int syn, input bit corr, input bit bad);
    exp_t e;
    e.data = d;
    e.syn  = 4'(syn);
    e.corr = corr;
    e.bad  = bad;
    return e;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v < lim) ? v + 1 : lim;
  endfunction

  // Monitor/scoreboard, sampled mid-cycle; a handshake seen here happens at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_words = 0; m_corr = 0; m_bad = 0;
      s_words = 0; s_corr = 0; s_bad = 0;
      prev_stall = 0;
    end else begin
      chk("cnt_words", 32'(cnt_words), 32'(m_words));
      chk("cnt_corr", 32'(cnt_corr), 32'(m_corr));
      chk("cnt_bad", 32'(cnt_bad), 32'(m_bad));
      chk("sat_cnt_words", 32'(d2_cnt_words), 32'(s_words));
      chk("sat_cnt_corr", 32'(d2_cnt_corr), 32'(s_corr));
      chk("sat_cnt_bad", 32'(d2_cnt_bad), 32'(s_bad));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_fields", 32'({out_data, out_syn, out_corr, out_bad}), 32'(prev_fields));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(mon_e.data));
          chk("out_syn", 32'(out_syn), 32'(mon_e.syn));
          chk("out_corr", 32'(out_corr), 32'(mon_e.corr));
          chk("out_bad", 32'(out_bad), 32'(mon_e.bad));
          if (!cnt_clr) begin
            m_words = sat(m_words, 65535);
            s_words = sat(s_words, 3);
            if (mon_e.corr) begin m_corr = sat(m_corr, 65535); s_corr = sat(s_corr, 3); end
            if (mon_e.bad)  begin m_bad  = sat(m_bad, 65535);  s_bad  = sat(s_bad, 3);  end
          end
        end
      end
      if (cnt_clr) begin
        m_words = 0; m_corr = 0; m_bad = 0;
        s_words = 0; s_corr = 0; s_bad = 0;
      end
      if (in_valid && in_ready) sb.push_back(exp_cur);
      prev_stall  = out_valid && !out_ready;
      prev_fields = {out_data, out_syn, out_corr, out_bad};
    end
  end

  task automatic send(input logic [0:8] cw, input exp_t e);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = cw;
    exp_cur  = e;
    acc = 0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:8] cw, f;
    logic [0:4] d;
    logic [0:4] bp_d[4];
    bit done;
    int n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_fields", 32'({out_data, out_syn, out_corr, out_bad}), 32'd0);
    chk("rst_cnt_words", 32'(cnt_words), 32'd0);
    @(posedge clk); #1;

    // Directed vectors with latency check on the first one
    send(9'b011001100, mk(5'b10110, 0, 0, 0));
    @(negedge clk);
    chk("lat_first_cycle", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_second_cycle", 32'(out_valid), 32'd1);
    drain();
    chk("clean_cnt_words", 32'(cnt_words), 32'd1);
    send(9'b011011100, mk(5'b10110, 5, 1, 0));
    drain();
    chk("single_cnt_corr", 32'(cnt_corr), 32'd1);
    send(9'b001001110, mk(5'b10110, 10, 0, 1));
    drain();
    chk("uncorr_cnt_bad", 32'(cnt_bad), 32'd1);
    chk("uncorr_cnt_words", 32'(cnt_words), 32'd3);

    // Backpressure: two words fill the pipe, then input stalls
    bp_d[0] = 5'b00001; bp_d[1] = 5'b10010; bp_d[2] = 5'b01111; bp_d[3] = 5'b11000;
    out_ready = 1'b0;
    send(encode(bp_d[0]), mk(bp_d[0], 0, 0, 0));
    send(encode(bp_d[1]), mk(bp_d[1], 0, 0, 0));
    in_valid = 1'b1;
    in_data  = encode(bp_d[2]);
    exp_cur  = mk(bp_d[2], 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_data_hold", 32'(out_data), 32'(bp_d[0]));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    chk("bp_ready_resume", 32'(in_ready), 32'd1);
    fork
      begin
        send(encode(bp_d[2]), mk(bp_d[2], 0, 0, 0));
        send(encode(bp_d[3]), mk(bp_d[3], 0, 0, 0));
      end
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_back_to_back", 32'(out_valid), 32'd1);
        end
      end
    join
    drain();
    chk("bp_cnt_words", 32'(cnt_words), 32'd7);

    // Every data value clean, then with each single-bit channel error
    for (int v = 0; v < 32; v++) begin
      d  = 5'(v);
      cw = encode(d);
      send(cw, mk(d, 0, 0, 0));
      for (int i = 0; i < 9; i++) begin
        f = cw;
        f[i] = ~f[i];
        send(f, mk(d, i + 1, 1, 0));
      end
    end
    drain();
    chk("sat2_cnt_words", 32'(d2_cnt_words), 32'd3);
    chk("sat2_cnt_corr", 32'(d2_cnt_corr), 32'd3);

    // Clear during an output handshake
    out_ready = 1'b0;
    send(encode(5'b10101), mk(5'b10101, 0, 0, 0));
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("clr_word_ready", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt_words", 32'(cnt_words), 32'd0);
    chk("clr_cnt_corr", 32'(cnt_corr), 32'd0);
    chk("clr_cnt_bad", 32'(cnt_bad), 32'd0);
    chk("clr_sat_words", 32'(d2_cnt_words), 32'd0);
    @(posedge clk); #1;

    // Random words (including multi-bit errors) under random backpressure
    done = 0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          cw = 9'($urandom);
          send(cw, model_decode(cw));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          if (!done) out_ready = 1'($urandom & 1);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two words in flight
    out_ready = 1'b0;
    send(encode(5'b00111), mk(5'b00111, 0, 0, 0));
    send(encode(5'b11100), mk(5'b11100, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_cnt_words", 32'(cnt_words), 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_output", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
